ub_scheduler: RTL and testbench

Controller that sequences and shares the unified buffer's single command port between three requesters: the compute unit (tile read/write), the store path (16-bit word read/write), and the host byte stream (16-bit words moved as two 8-bit fifo transactions). It sits between the requesters and the buffer. It arbitrates round-robin, drives every buffer control line and the fifo byte lane, and returns per-requester completion strobes.

---
 rtl/ub_pkg.sv | 17 +
 rtl/ub_scheduler_if.sv | 30 +++
 rtl/ub_rr_arbiter.sv | 24 ++
 rtl/ub_scheduler.sv | 99 +++++++++
 tb/tb_ub_scheduler.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ub_pkg.sv
// ub_pkg: shared types and geometry for the unified-buffer scheduler.
package ub_pkg;
    localparam int ADDRESS_SIZE    = 10;
    localparam int BUFFER_SIZE     = 1024;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int LANES           = 64;
    localparam int LANE_BITS       = 4;
    localparam int WORD_BITS       = 16;
    localparam int TILE_WORDS      = LANES * LANE_BITS / WORD_BITS;

    typedef enum logic [2:0] {IDLE, CMD, RESP, HOST_LO, HOST_HI, HOST_FIN, REJECT} state_e;
    typedef enum logic [1:0] {REQ_CMP, REQ_ST, REQ_HOST} req_e;

    function automatic req_e next_req(req_e r);
        return r == REQ_CMP ? REQ_ST : r == REQ_ST ? REQ_HOST : REQ_CMP;
    endfunction
endpackage

// File: rtl/ub_scheduler_if.sv
// ub_scheduler_if: requester handshakes plus the buffer command port.
interface ub_scheduler_if;
    import ub_pkg::*;
    logic                         cmp_req, cmp_we, cmp_gnt, cmp_done, cmp_err;
    logic [ADDRESS_SIZE-1:0]      cmp_addr;
    logic                         st_req, st_we, st_gnt, st_done;
    logic [ADDRESS_SIZE-1:0]      st_addr;
    logic                         host_req, host_we, host_gnt, host_done;
    logic [ADDRESS_SIZE-1:0]      host_addr;
    logic [2*FIFO_DATA_WIDTH-1:0] host_wdata, host_rdata;
    logic                         ub_we, ub_re, ub_compute_en, ub_fifo_en, ub_store_en, ub_section;
    logic [ADDRESS_SIZE-1:0]      ub_address;
    logic [FIFO_DATA_WIDTH-1:0]   ub_fifo_in, ub_fifo_out;
    logic                         ub_done, busy, err;

    modport slave (
        input  cmp_req, cmp_we, cmp_addr, st_req, st_we, st_addr,
               host_req, host_we, host_addr, host_wdata, ub_fifo_out, ub_done,
        output cmp_gnt, cmp_done, cmp_err, st_gnt, st_done, host_gnt, host_done, host_rdata,
               ub_we, ub_re, ub_compute_en, ub_fifo_en, ub_store_en, ub_section,
               ub_address, ub_fifo_in, busy, err
    );
    modport master (
        output cmp_req, cmp_we, cmp_addr, st_req, st_we, st_addr,
               host_req, host_we, host_addr, host_wdata, ub_fifo_out, ub_done,
        input  cmp_gnt, cmp_done, cmp_err, st_gnt, st_done, host_gnt, host_done, host_rdata,
               ub_we, ub_re, ub_compute_en, ub_fifo_en, ub_store_en, ub_section,
               ub_address, ub_fifo_in, busy, err
    );
endinterface

// File: rtl/ub_rr_arbiter.sv
// ub_rr_arbiter: 3-way round-robin; search starts at the pointer, pointer moves past the winner.
module ub_rr_arbiter
    import ub_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req_i,
    input  logic       adv_i,
    output logic [2:0] gnt_o
);
    req_e ptr_q, ptr_d, p1, p2, win;

    always_comb begin
        p1    = next_req(ptr_q);
        p2    = next_req(p1);
        win   = req_i[ptr_q] ? ptr_q : req_i[p1] ? p1 : p2;
        gnt_o = |req_i ? 3'b001 << win : 3'b000;
        ptr_d = adv_i && |req_i ? next_req(win) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= REQ_CMP;
        else        ptr_q <= ptr_d;
endmodule

// File: rtl/ub_scheduler.sv
// ub_scheduler: shares the unified buffer command port between compute, store and host requesters.
module ub_scheduler
    import ub_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    ub_scheduler_if.slave bus
);
    localparam int W = FIFO_DATA_WIDTH;

    state_e                  state_q, state_d;
    req_e                    who_q;
    logic                    we_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [2*W-1:0]          wdata_q, rdata_q;
    logic                    cmp_done_q, cmp_err_q, st_done_q, host_done_q, err_q;
    logic [2:0]              gnt;
    logic                    arb_en, reject, miss, cmd, hlo, hhi, act;

    // the IDLE cycle carrying a host-read done pulse is not a grant slot
    assign arb_en = rst_n && state_q == IDLE && !host_done_q;

    ub_rr_arbiter u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({bus.host_req, bus.st_req, bus.cmp_req} & {3{arb_en}}),
        .adv_i (arb_en),
        .gnt_o (gnt)
    );

    always_comb begin
        reject  = gnt[REQ_CMP] && int'(bus.cmp_addr) + TILE_WORDS > BUFFER_SIZE;
        miss    = !bus.ub_done && (state_q == RESP || state_q == HOST_HI || state_q == HOST_FIN);
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = reject ? REJECT : gnt[REQ_HOST] ? HOST_LO : |gnt ? CMD : IDLE;
            CMD:      state_d = RESP;
            HOST_LO:  state_d = HOST_HI;
            HOST_HI:  state_d = HOST_FIN;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            who_q       <= REQ_CMP;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cmp_done_q  <= 1'b0;
            cmp_err_q   <= 1'b0;
            st_done_q   <= 1'b0;
            host_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (|gnt) begin
                who_q   <= gnt[REQ_CMP] ? REQ_CMP : gnt[REQ_ST] ? REQ_ST : REQ_HOST;
                we_q    <= gnt[REQ_CMP] ? bus.cmp_we : gnt[REQ_ST] ? bus.st_we : bus.host_we;
                addr_q  <= gnt[REQ_CMP] ? bus.cmp_addr : gnt[REQ_ST] ? bus.st_addr : bus.host_addr;
                wdata_q <= bus.host_wdata;
            end
            cmp_done_q  <= reject || (state_q == CMD && who_q == REQ_CMP);
            cmp_err_q   <= reject;
            st_done_q   <= state_q == CMD && who_q == REQ_ST;
            // host reads finish one cycle later so the high byte lands with done
            host_done_q <= we_q ? state_q == HOST_HI : state_q == HOST_FIN;
            err_q       <= err_q || reject || miss;
            if (!we_q && state_q == HOST_HI)  rdata_q[W-1:0]   <= bus.ub_fifo_out;
            if (!we_q && state_q == HOST_FIN) rdata_q[2*W-1:W] <= bus.ub_fifo_out;
        end
    end

    assign cmd = state_q == CMD;
    assign hlo = state_q == HOST_LO;
    assign hhi = state_q == HOST_HI;
    assign act = cmd || hlo || hhi;

    assign bus.cmp_gnt       = gnt[REQ_CMP];
    assign bus.st_gnt        = gnt[REQ_ST];
    assign bus.host_gnt      = gnt[REQ_HOST];
    assign bus.cmp_done      = cmp_done_q;
    assign bus.cmp_err       = cmp_err_q;
    assign bus.st_done       = st_done_q;
    assign bus.host_done     = host_done_q;
    assign bus.host_rdata    = rdata_q;
    assign bus.err           = err_q;
    assign bus.busy          = state_q != IDLE;
    assign bus.ub_we         = act && we_q;
    assign bus.ub_re         = act && !we_q;
    assign bus.ub_compute_en = cmd && who_q == REQ_CMP;
    assign bus.ub_store_en   = cmd && who_q == REQ_ST;
    assign bus.ub_fifo_en    = hlo || hhi;
    assign bus.ub_section    = hhi;
    assign bus.ub_address    = act ? addr_q : '0;
    assign bus.ub_fifo_in    = hlo ? wdata_q[W-1:0] : hhi ? wdata_q[2*W-1:W] : '0;
endmodule

// File: tb/tb_ub_scheduler.sv
// tb_ub_scheduler: directed vector table plus hand sequences for rotation, missing done and mid-op reset.
module tb_ub_scheduler;
    import ub_pkg::*;

    typedef struct {
        req_e        kind;
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wdata;
        int          lat;
        logic        en;
        logic [9:0]  eaddr;
        logic [7:0]  lo, hi;
        logic [15:0] rdata;
        logic        cerr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       done_en;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] mem [0:2047];
    vec_t       vecs [6];

    ub_scheduler_if bus();
    ub_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // buffer model: acknowledges any command one cycle later and stores fifo bytes
    always @(posedge clk) begin
        bus.ub_done <= done_en && (bus.ub_we || bus.ub_re);
        if (bus.ub_fifo_en) begin
            if (bus.ub_we) mem[{bus.ub_address, bus.ub_section}] <= bus.ub_fifo_in;
            bus.ub_fifo_out <= mem[{bus.ub_address, bus.ub_section}];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic gnt_of(req_e k);
        return k == REQ_CMP ? bus.cmp_gnt : k == REQ_ST ? bus.st_gnt : bus.host_gnt;
    endfunction

    function automatic logic done_of(req_e k);
        return k == REQ_CMP ? bus.cmp_done : k == REQ_ST ? bus.st_done : bus.host_done;
    endfunction

    function automatic logic en_of(req_e k);
        return k == REQ_CMP ? bus.ub_compute_en : k == REQ_ST ? bus.ub_store_en : bus.ub_fifo_en;
    endfunction

    task automatic set_req(input req_e k, input logic on, input logic we, input logic [9:0] a, input logic [15:0] wd);
        bus.cmp_req    = on && k == REQ_CMP;
        bus.st_req     = on && k == REQ_ST;
        bus.host_req   = on && k == REQ_HOST;
        bus.cmp_we     = we;
        bus.st_we      = we;
        bus.host_we    = we;
        bus.cmp_addr   = a;
        bus.st_addr    = a;
        bus.host_addr  = a;
        bus.host_wdata = wd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_vec(input vec_t v);
        int         k;
        logic       g, done, en1, we1, re1, busy1;
        logic [9:0] a1;
        logic [7:0] b1, b2;
        logic [15:0] rd;
        logic       ce;
        @(posedge clk); #1;
        set_req(v.kind, 1'b1, v.we, v.addr, v.wdata);
        g = 1'b0;
        for (int i = 0; i < 20 && !g; i++) begin
            @(negedge clk);
            g = gnt_of(v.kind);
        end
        chk("gnt", g, 1);
        @(posedge clk); #1;
        set_req(v.kind, 1'b0, v.we, v.addr, v.wdata);
        k = 1; done = 1'b0;
        {en1, we1, re1, busy1, a1, b1, b2, rd, ce} = '0;
        while (!done && k < 10) begin
            @(negedge clk);
            if (k == 1) begin
                a1 = bus.ub_address; we1 = bus.ub_we; re1 = bus.ub_re;
                en1 = en_of(v.kind); b1 = bus.ub_fifo_in; busy1 = bus.busy;
            end
            if (k == 2) b2 = bus.ub_fifo_in;
            if (done_of(v.kind)) begin
                done = 1'b1; rd = bus.host_rdata; ce = bus.cmp_err;
            end else k++;
        end
        chk("latency", k, v.lat);
        chk("busy", busy1, 1);
        chk("ub_address", a1, v.eaddr);
        chk("ub_en", en1, v.en);
        chk("ub_we", we1, v.en && v.we);
        chk("ub_re", re1, v.en && !v.we);
        if (v.kind == REQ_HOST && v.we) begin
            chk("fifo_lo", b1, v.lo);
            chk("fifo_hi", b2, v.hi);
        end
        if (v.kind == REQ_HOST && !v.we) chk("host_rdata", rd, v.rdata);
        if (v.kind == REQ_CMP) chk("cmp_err", ce, v.cerr);
    endtask

    initial begin
        int         ord [12];
        int         at [12];
        int         n, cyc;
        logic       g, s, hd;
        vecs[0] = '{REQ_CMP,  1'b1, 10'h010, 16'h0000, 2, 1'b1, 10'h010, 8'h00, 8'h00, 16'h0000, 1'b0};
        vecs[1] = '{REQ_ST,   1'b0, 10'h055, 16'h0000, 2, 1'b1, 10'h055, 8'h00, 8'h00, 16'h0000, 1'b0};
        vecs[2] = '{REQ_HOST, 1'b1, 10'h020, 16'hBEEF, 3, 1'b1, 10'h020, 8'hEF, 8'hBE, 16'h0000, 1'b0};
        vecs[3] = '{REQ_HOST, 1'b0, 10'h020, 16'h1234, 4, 1'b1, 10'h020, 8'h00, 8'h00, 16'hBEEF, 1'b0};
        vecs[4] = '{REQ_CMP,  1'b0, 10'h3F0, 16'h0000, 2, 1'b1, 10'h3F0, 8'h00, 8'h00, 16'h0000, 1'b0};
        vecs[5] = '{REQ_CMP,  1'b1, 10'h3F1, 16'h0000, 1, 1'b0, 10'h000, 8'h00, 8'h00, 16'h0000, 1'b1};

        rst_n = 1'b0;
        done_en = 1'b1;
        set_req(REQ_CMP, 1'b0, 1'b0, 10'h000, 16'h0000);
        repeat (3) @(negedge clk);
        chk("rst_gnt", {bus.cmp_gnt, bus.st_gnt, bus.host_gnt}, 0);
        chk("rst_done", {bus.cmp_done, bus.st_done, bus.host_done, bus.cmp_err}, 0);
        chk("rst_err_busy", {bus.err, bus.busy}, 0);
        chk("rst_ctl", {bus.ub_we, bus.ub_re, bus.ub_compute_en, bus.ub_fifo_en, bus.ub_store_en, bus.ub_section}, 0);
        chk("rst_addr", bus.ub_address, 0);
        chk("rst_fifo_in", bus.ub_fifo_in, 0);
        chk("rst_rdata", bus.host_rdata, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) do_vec(vecs[i]);
        @(negedge clk);
        chk("err_clean", bus.err, 0);
        do_vec(vecs[5]);
        @(negedge clk);
        chk("err_reject", bus.err, 1);

        do_reset();
        chk("err_cleared", bus.err, 0);
        @(posedge clk); #1;
        bus.cmp_req = 1'b1; bus.cmp_we = 1'b0; bus.cmp_addr = 10'h000;
        bus.st_req = 1'b1; bus.st_we = 1'b1; bus.st_addr = 10'h100;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 10'h020;
        n = 0; cyc = 0;
        while (n < 12 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.cmp_gnt || bus.st_gnt || bus.host_gnt) begin
                ord[n] = bus.cmp_gnt ? 0 : bus.st_gnt ? 1 : 2;
                at[n] = cyc;
                n++;
            end
        end
        @(posedge clk); #1;
        set_req(REQ_CMP, 1'b0, 1'b0, 10'h000, 16'h0000);
        chk("rot_count", n, 12);
        for (int i = 0; i < n; i++) chk("rot_order", ord[i], i % 3);
        for (int i = 0; i + 1 < n; i++) chk("rot_spacing", at[i+1] - at[i], ord[i] == 2 ? 5 : 3);
        repeat (6) @(negedge clk);
        chk("rot_err", bus.err, 0);

        done_en = 1'b0;
        do_vec('{REQ_ST, 1'b1, 10'h100, 16'h0000, 2, 1'b1, 10'h100, 8'h00, 8'h00, 16'h0000, 1'b0});
        @(negedge clk);
        chk("miss_err", bus.err, 1);
        done_en = 1'b1;
        do_vec(vecs[0]);
        @(negedge clk);
        chk("miss_sticky", bus.err, 1);
        do_reset();
        chk("miss_cleared", bus.err, 0);

        @(posedge clk); #1;
        set_req(REQ_HOST, 1'b1, 1'b1, 10'h030, 16'hA55A);
        g = 1'b0;
        for (int i = 0; i < 20 && !g; i++) begin
            @(negedge clk);
            g = bus.host_gnt;
        end
        chk("abort_gnt", g, 1);
        @(posedge clk); #1;
        set_req(REQ_HOST, 1'b0, 1'b1, 10'h030, 16'hA55A);
        s = 1'b0;
        for (int i = 0; i < 10 && !s; i++) begin
            @(negedge clk);
            s = bus.ub_section;
        end
        chk("abort_in_hi", s, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_fifo_en", bus.ub_fifo_en, 0);
        chk("abort_busy", bus.busy, 0);
        hd = 1'b0;
        repeat (3) begin
            @(negedge clk);
            hd = hd | bus.host_done;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            hd = hd | bus.host_done;
        end
        chk("abort_no_done", hd, 0);
        @(posedge clk); #1;
        bus.cmp_req = 1'b1; bus.cmp_we = 1'b0; bus.cmp_addr = 10'h000;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 10'h020;
        g = 1'b0;
        for (int i = 0; i < 20 && !g; i++) begin
            @(negedge clk);
            g = bus.cmp_gnt || bus.st_gnt || bus.host_gnt;
            if (g) chk("post_rst_winner", {bus.cmp_gnt, bus.st_gnt, bus.host_gnt}, 3'b100);
        end
        chk("post_rst_gnt", g, 1);
        @(posedge clk); #1;
        set_req(REQ_CMP, 1'b0, 1'b0, 10'h000, 16'h0000);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
